// File: rtl/hybridcore_seq_pkg.sv
// Shared definitions for the hybridcore program sequencer.
// Holds the sequencer state encoding, default sizing and the
// program-length legality check used when a run is requested.
package hybridcore_seq_pkg;

  localparam int unsigned DEF_IW     = 32;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_LOOP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // A run needs at least one instruction and cannot exceed the store.
  function automatic logic prog_len_ok(input logic [31:0] len, input int unsigned depth);
    return (len != 32'd0) && (len <= depth);
  endfunction

endpackage

// File: rtl/hybridcore_prog_mem.sv
// Program store: DEPTH x IW register array, synchronous write,
// asynchronous read, contents survive reset.
// Ports:
//   clk      clock
//   we_i     write strobe
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  combinational read data
module hybridcore_prog_mem #(
  parameter int unsigned IW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [DEPTH];

  // Storage write; no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hybridcore_program_sequencer.sv
// Instruction feeder for hybridcore_processor: loadable program store
// issued over a valid/ready port, with runtime length, repeat passes
// and abort.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   load_en/addr/data      program store write (IDLE only)
//   start                  begin a run (IDLE only)
//   abort                  terminate a run in progress
//   prog_len               instructions per pass (1..DEPTH)
//   loop_count             extra passes after the first
//   instr_out/valid/ready  issue port to the core
//   pc_out                 store index of instr_out
//   busy                   sequencer not idle
//   done                   one-cycle pulse at normal completion
//   err                    one-cycle pulse on an illegal request
module hybridcore_program_sequencer
  import hybridcore_seq_pkg::*;
#(
  parameter int unsigned IW     = DEF_IW,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned LOOP_W = DEF_LOOP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [IW-1:0]     load_data,
  input  logic              start,
  input  logic              abort,
  input  logic [AW:0]       prog_len,
  input  logic [LOOP_W-1:0] loop_count,
  output logic [IW-1:0]     instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [AW-1:0]     pc_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW:0]       len_q, len_d;
  logic [LOOP_W-1:0] passes_q, passes_d;
  logic [IW-1:0]     instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              mem_we_c;
  logic [AW-1:0]     rd_addr_c;
  logic [IW-1:0]     rd_data_c;
  logic              last_c;
  logic [AW-1:0]     pc_inc_c;

  // Store writes are only honoured while idle.
  assign mem_we_c = load_en && (state_q == ST_IDLE);

  hybridcore_prog_mem #(
    .IW   (IW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we_c),
    .waddr_i(load_addr),
    .wdata_i(load_data),
    .raddr_i(rd_addr_c),
    .rdata_o(rd_data_c)
  );

  // Last word of the pass; compared one bit wider so len==DEPTH works.
  assign last_c   = ((AW+1)'(pc_q) + (AW+1)'(1)) == len_q;
  assign pc_inc_c = pc_q + AW'(1);

  // Read address is the word to present next cycle: pc+1, or 0 on wrap/start.
  always_comb begin
    rd_addr_c = '0;
    if ((state_q == ST_RUN) && !last_c) begin
      rd_addr_c = pc_inc_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    passes_d = passes_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // load_en wins over start; start is dropped silently.
        if (!load_en && start) begin
          if (prog_len_ok(32'(prog_len), DEPTH)) begin
            len_d    = prog_len;
            passes_d = loop_count;
            pc_d     = '0;
            instr_d  = rd_data_c;
            valid_d  = 1'b1;
            state_d  = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (load_en) begin
          err_d = 1'b1;
        end
        // Abort overrides a same-cycle transfer; pc is left where it was.
        if (abort) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (valid_q && instr_ready) begin
          if (!last_c) begin
            pc_d    = pc_inc_c;
            instr_d = rd_data_c;
          end else if (passes_q != '0) begin
            passes_d = passes_q - LOOP_W'(1);
            pc_d     = '0;
            instr_d  = rd_data_c;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (load_en) begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      passes_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      passes_q <= passes_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: doc/hybridcore_program_sequencer.md
Name: hybridcore_program_sequencer

Overview:
Parametrised instruction feeder for hybridcore_processor. It replaces fixed hand-stepped program issue with a loadable program store and a valid/ready issue port.
- Program length is runtime-selectable; the program can be repeated N extra passes; the run can be aborted.
- Sits between the program loader (bench or boot logic) and the core's instruction input.

Parameters:
IW, 32, instruction width in bits
DEPTH, 16, program store entries (power of two, >=2)
AW, $clog2(DEPTH), store address width
LOOP_W, 8, width of extra-pass counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  write strobe into program store
load_addr  in  AW  store write address
load_data  in  IW  store write data
start  in  1  begin run (sampled in IDLE only)
abort  in  1  terminate run
prog_len  in  AW+1  instructions per pass, legal 1..DEPTH
loop_count  in  LOOP_W  extra passes after the first
instr_out  out  IW  instruction to core
instr_valid  out  1  instr_out is valid
instr_ready  in  1  core accepts instr_out
pc_out  out  AW  store index of instr_out
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at normal completion
err  out  1  one-cycle pulse on illegal request

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - instr_out=0, instr_valid=0, pc_out=0, busy=0, done=0, err=0.
  - Internal pass counter=0.
  - Program store contents are not reset.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - load_en=1 writes mem[load_addr]=load_data at the clock edge. load_en has priority; start in the same cycle is ignored without err.
  - start=1 with prog_len in 1..DEPTH: latch len, passes_left=loop_count, pc=0. Next cycle: state=RUN, instr_valid=1, instr_out=mem[0], pc_out=0.
  - start=1 with prog_len=0 or prog_len>DEPTH: err=1 for one cycle; stay in IDLE.
- RUN, issue rules:
  - A transfer is a cycle with instr_valid&&instr_ready.
  - instr_out and pc_out are held stable while instr_valid&&!instr_ready.
  - On transfer with pc<len-1: pc+1, next word presented the next cycle. Throughput is 1 instr/cycle with ready held high.
  - On transfer with pc==len-1 and passes_left>0: passes_left-1, pc wraps to 0, mem[0] presented the next cycle with no bubble.
  - On transfer with pc==len-1 and passes_left==0: instr_valid=0 next cycle, state=DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- load_en while busy: write is ignored, err=1 for one cycle. start while busy is ignored silently.
- abort in RUN (highest priority, also over a same-cycle transfer): next cycle instr_valid=0, state=IDLE, no done pulse. A transfer coincident with abort counts as accepted by the core, but pc does not advance.
- abort in IDLE or DONE: no effect.
- rst_n deasserted mid-run: outputs clear immediately, asynchronously; a fresh start is required to resume.
- Total issued instructions = len*(loop_count+1).

Decomposition:
- Package hybridcore_seq_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default IW/DEPTH/LOOP_W localparams
  - a function validating prog_len against DEPTH
- Sub-module hybridcore_prog_mem:
  - DEPTH x IW register array
  - synchronous write, asynchronous read
  - no reset
- The sequencer instantiates one hybridcore_prog_mem and registers its read output into instr_out.

Test Plan:
- Basic run: load mem[0..3]=06410005,06420003,04430002,05440004; prog_len=4, loop_count=0, ready=1, start pulse -> valid high 4 consecutive cycles from start+1 with those words in order, pc_out 0..3, done pulse on the cycle after the last transfer, busy low one cycle after that.
- Backpressure: same program, ready=0 for 3 cycles while pc_out=1 -> instr_out holds 06420003 all 3 cycles, exactly 4 transfers total, no word duplicated or skipped.
- Looping: prog_len=3, loop_count=2 -> 9 transfers, pc_out sequence 0,1,2,0,1,2,0,1,2 with no bubble at wrap, single done pulse.
- Abort: prog_len=8, abort asserted on the cycle pc_out=3 with ready=1 -> valid low next cycle, busy low, done never asserted. A subsequent start restarts at pc_out=0.
- Illegal requests: start with prog_len=0 -> err pulse, busy stays 0. load_en during RUN -> err pulse and mem unchanged (verified by rerun).
- Async reset: assert rst_n=0 mid-cycle during RUN -> instr_valid, busy, pc_out go to 0 before the next clk edge. Store contents are preserved (rerun reproduces the previous sequence).
